// File: rtl/conv_window_if.sv
// conv_window_if: handshake/data bundle between the convolution sequencer and its environment
interface conv_window_if #(
  parameter int PW = 8,
  parameter int KW = 8
);
  logic          start;
  logic [3:0]    m;
  logic          conv_complete;
  logic [PW-1:0] pix_data;
  logic [KW-1:0] ker_data;
  logic          fetch;
  logic          slide;
  logic [9:0]    pixel_count;
  logic [6:0]    ker_addr;
  logic          res_we;
  logic [7:0]    res_data;
  logic [15:0]   win_count;
  logic          busy;
  logic          done;
  logic          err;
  modport master (
    output start, m, conv_complete, pix_data, ker_data,
    input  fetch, slide, pixel_count, ker_addr, res_we, res_data, win_count, busy, done, err
  );
  modport slave (
    input  start, m, conv_complete, pix_data, ker_data,
    output fetch, slide, pixel_count, ker_addr, res_we, res_data, win_count, busy, done, err
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: window sequencer and MAC producing one saturated 8-bit result per window
module conv_window_ctrl #(
  parameter int PW    = 8,
  parameter int KW    = 8,
  parameter int AW    = 24,
  parameter int SHIFT = 4
) (
  input logic         clk,
  input logic         rst,
  conv_window_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, SLIDE, DONE} state_t;
  state_t                state, state_nx;
  logic [3:0]            m_r;
  logic [7:0]            mm;
  logic [9:0]            last, pc;
  logic                  vld, err_r, legal, accept;
  logic [15:0]           wc;
  logic signed [PW+KW:0] prod;
  logic signed [AW-1:0]  acc, sh;
  assign legal  = bus.m[0] && bus.m <= 4'd9;
  assign accept = state == IDLE && bus.start && legal;
  assign mm     = m_r * m_r;
  assign last   = {2'b0, mm} - 10'd1;
  assign prod   = $signed({1'b0, bus.pix_data}) * $signed(bus.ker_data);
  assign sh     = acc >>> SHIFT;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // next state and state-decoded strobes
  always_comb begin
    state_nx        = state;
    bus.fetch       = state == FETCH;
    bus.slide       = state == SLIDE;
    bus.res_we      = state == WRITE;
    bus.done        = state == DONE;
    bus.busy        = state != IDLE;
    bus.pixel_count = pc;
    bus.ker_addr    = pc[6:0];
    bus.win_count   = wc;
    bus.err         = err_r;
    bus.res_data    = sh[AW-1] ? 8'd0 : (|sh[AW-2:8]) ? 8'hff : sh[7:0];
    case (state)
      IDLE:    state_nx = accept ? FETCH : IDLE;
      FETCH:   state_nx = pc == last ? DRAIN : FETCH;
      DRAIN:   state_nx = WRITE;
      WRITE:   state_nx = SLIDE;
      SLIDE:   state_nx = bus.conv_complete ? DONE : FETCH;
      default: state_nx = IDLE;
    endcase
  end
  // window index, read-data valid pipe, accumulator and result counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_r   <= '0;
      pc    <= '0;
      vld   <= 1'b0;
      err_r <= 1'b0;
      wc    <= '0;
      acc   <= '0;
    end else begin
      vld   <= state == FETCH;
      err_r <= state == IDLE && bus.start && !legal;
      pc    <= (state == FETCH && pc != last) ? pc + 10'd1 : '0;
      if (accept) begin
        m_r <= bus.m;
        wc  <= '0;
        acc <= '0;
      end else if (state == WRITE) begin
        wc  <= wc + 16'd1;
        acc <= '0;
      end else if (vld)
        acc <= acc + {{(AW-PW-KW-1){prod[PW+KW]}}, prod};
    end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: directed scenario tests for conv_window_ctrl
module tb_conv_window_ctrl;
  logic clk, rst;
  int   errors, checks;
  conv_window_if bus ();
  conv_window_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic begin_run(input logic [3:0] mv);
    bus.m     = mv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.fetch, bus.slide, bus.res_we, bus.busy, bus.done, bus.err} !== 6'b0 || bus.pixel_count !== 10'd0 ||
        bus.ker_addr !== 7'd0 || bus.res_data !== 8'd0 || bus.win_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state fetch=%b slide=%b we=%b busy=%b done=%b err=%b pc=%0d ka=%0d rd=%0d wc=%0d expected all 0",
               bus.fetch, bus.slide, bus.res_we, bus.busy, bus.done, bus.err, bus.pixel_count, bus.ker_addr, bus.res_data, bus.win_count);
    end
    rst = 1'b0;
    bus.pix_data = 8'd16;
    bus.ker_data = 8'd1;
    begin_run(4'd1);
    repeat (9) tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.win_count !== 16'd2) begin
      errors++;
      $display("FAIL reset_prerun busy=%b wc=%0d expected busy=1 wc=2", bus.busy, bus.win_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.fetch, bus.slide, bus.res_we, bus.busy, bus.done, bus.err} !== 6'b0 || bus.pixel_count !== 10'd0 ||
        bus.res_data !== 8'd0 || bus.win_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_midrun fetch=%b slide=%b we=%b busy=%b done=%b err=%b pc=%0d rd=%0d wc=%0d expected all 0",
               bus.fetch, bus.slide, bus.res_we, bus.busy, bus.done, bus.err, bus.pixel_count, bus.res_data, bus.win_count);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.fetch !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b fetch=%b expected 0 0", bus.busy, bus.fetch);
    end
  endtask
  task automatic test_basic;
    bus.pix_data = 8'd16;
    bus.ker_data = 8'd1;
    begin_run(4'd3);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bus.fetch !== 1'b1 || bus.pixel_count !== 10'(i) || bus.ker_addr !== 7'(i)) begin
        errors++;
        $display("FAIL basic_fetch i=%0d fetch=%b pc=%0d ka=%0d expected fetch=1 pc=%0d", i, bus.fetch, bus.pixel_count, bus.ker_addr, i);
      end
      tick();
    end
    checks++;
    if (bus.fetch !== 1'b0 || bus.res_we !== 1'b0 || bus.busy !== 1'b1 || bus.pixel_count !== 10'd0) begin
      errors++;
      $display("FAIL basic_drain fetch=%b we=%b busy=%b pc=%0d expected 0 0 1 0", bus.fetch, bus.res_we, bus.busy, bus.pixel_count);
    end
    tick();
    checks++;
    if (bus.res_we !== 1'b1 || bus.res_data !== 8'd9 || bus.win_count !== 16'd0) begin
      errors++;
      $display("FAIL basic_write we=%b rd=%0d wc=%0d expected we=1 rd=9 wc=0", bus.res_we, bus.res_data, bus.win_count);
    end
    tick();
    checks++;
    if (bus.slide !== 1'b1 || bus.res_we !== 1'b0 || bus.win_count !== 16'd1) begin
      errors++;
      $display("FAIL basic_slide slide=%b we=%b wc=%0d expected slide=1 we=0 wc=1", bus.slide, bus.res_we, bus.win_count);
    end
    bus.conv_complete = 1'b1;
    tick();
    bus.conv_complete = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.slide !== 1'b0) begin
      errors++;
      $display("FAIL basic_done done=%b busy=%b slide=%b expected 1 1 0", bus.done, bus.busy, bus.slide);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.win_count !== 16'd1) begin
      errors++;
      $display("FAIL basic_idle busy=%b done=%b wc=%0d expected 0 0 1", bus.busy, bus.done, bus.win_count);
    end
  endtask
  task automatic test_saturation;
    logic [7:0] kv, ev;
    for (int k = 0; k < 2; k++) begin
      kv = (k == 0) ? 8'd127 : 8'hff;
      ev = (k == 0) ? 8'd255 : 8'd0;
      bus.pix_data = 8'd255;
      bus.ker_data = kv;
      begin_run(4'd3);
      repeat (10) tick();
      checks++;
      if (bus.res_we !== 1'b1 || bus.res_data !== ev) begin
        errors++;
        $display("FAIL saturation ker=%0d we=%b rd=%0d expected we=1 rd=%0d", $signed(kv), bus.res_we, bus.res_data, ev);
      end
      bus.conv_complete = 1'b1;
      repeat (3) tick();
      bus.conv_complete = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL saturation_idle ker=%0d busy=%b expected 0", $signed(kv), bus.busy);
      end
    end
  endtask
  task automatic test_multi_window;
    int t, we_n, done_n, sl_n, first_we, last_we, gap_bad, data_bad;
    t = 1; we_n = 0; done_n = 0; sl_n = 0; first_we = 0; last_we = 0; gap_bad = 0; data_bad = 0;
    bus.pix_data = 8'd16;
    bus.ker_data = 8'd1;
    bus.conv_complete = 1'b0;
    begin_run(4'd5);
    while (t < 200) begin
      if (bus.res_we) begin
        if (bus.res_data !== 8'd25) data_bad++;
        if (we_n == 0) first_we = t;
        else if (t - last_we != 28) gap_bad++;
        last_we = t;
        we_n++;
      end
      if (bus.done) done_n++;
      if (bus.slide) begin
        sl_n++;
        if (sl_n == 3) bus.conv_complete = 1'b1;
      end
      if (!bus.busy) break;
      tick();
      t++;
    end
    bus.conv_complete = 1'b0;
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL multi_timeout cycles=%0d expected busy to drop before 200", t);
    end
    checks++;
    if (we_n != 3 || done_n != 1) begin
      errors++;
      $display("FAIL multi_pulses res_we=%0d done=%0d expected 3 1", we_n, done_n);
    end
    checks++;
    if (bus.win_count !== 16'd3 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL multi_final wc=%0d busy=%b expected 3 0", bus.win_count, bus.busy);
    end
    checks++;
    if (first_we != 27 || gap_bad != 0 || data_bad != 0) begin
      errors++;
      $display("FAIL multi_timing first_we=%0d gap_bad=%0d data_bad=%0d expected 27 0 0", first_we, gap_bad, data_bad);
    end
  endtask
  task automatic test_err;
    logic [3:0] mv;
    for (int k = 0; k < 2; k++) begin
      mv = (k == 0) ? 4'd4 : 4'd0;
      begin_run(mv);
      checks++;
      if (bus.err !== 1'b1 || bus.fetch !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse m=%0d err=%b fetch=%b busy=%b expected 1 0 0", mv, bus.err, bus.fetch, bus.busy);
      end
      tick();
      checks++;
      if (bus.err !== 1'b0 || bus.fetch !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL err_clear m=%0d err=%b fetch=%b busy=%b expected 0 0 0", mv, bus.err, bus.fetch, bus.busy);
      end
    end
  endtask
  task automatic test_reset_restart;
    int n;
    n = 0;
    bus.pix_data = 8'd200;
    bus.ker_data = 8'd5;
    bus.conv_complete = 1'b0;
    begin_run(4'd3);
    while (n < 100 && !(bus.win_count == 16'd1 && bus.pixel_count == 10'd4 && bus.fetch)) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL restart_reach cycles=%0d expected window 2 pc=4 within 100", n);
    end
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.pix_data = 8'd16;
    bus.ker_data = 8'd1;
    begin_run(4'd3);
    repeat (10) tick();
    checks++;
    if (bus.res_we !== 1'b1 || bus.res_data !== 8'd9) begin
      errors++;
      $display("FAIL restart_result we=%b rd=%0d expected we=1 rd=9", bus.res_we, bus.res_data);
    end
    tick();
    checks++;
    if (bus.win_count !== 16'd1 || bus.slide !== 1'b1) begin
      errors++;
      $display("FAIL restart_count wc=%0d slide=%b expected 1 1", bus.win_count, bus.slide);
    end
    bus.conv_complete = 1'b1;
    repeat (2) tick();
    bus.conv_complete = 1'b0;
  endtask
  initial begin
    errors = 0;
    checks = 0;
    bus.start = 1'b0;
    bus.m = 4'd0;
    bus.conv_complete = 1'b0;
    bus.pix_data = '0;
    bus.ker_data = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_multi_window();
    test_err();
    test_reset_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
